// File: rtl/mem_access_unit_if.sv
// Data-memory / cache bus between the MEM-stage load/store engine and memory.
// The unit drives address, lanes and strobes; memory answers with read data and BUSYWAIT.
interface mem_access_unit_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTEEN;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTEEN,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTEEN,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: memory handshake, lane alignment, load extension, pipeline stall.
// Optional macro MISALIGNED_TRAP_EN enables misaligned-access detection and the MISALIGNED flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for IN_DATAMEMSEL; stalls only for an aligned request
// S_ACCESS | strobe asserted, waiting for MEM_BUSYWAIT=0 or timeout
// S_DONE   | one cycle with stall released; MISALIGNED/BUS_ERROR valid here
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         IN_ADDRESS,
    input  logic [31:0]         IN_DATA2,
    input  logic                IN_DATAMEMSEL,
    input  logic [3:0]          IN_READ_WRITE,
    mem_access_unit_if.master   mem,
    output logic [31:0]         LOAD_DATA,
    output logic                BUSYWAIT,
    output logic                MISALIGNED,
    output logic                BUS_ERROR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 is_store;
    logic [2:0]           funct3;
    logic                 aligned;
    logic                 timeout;
    logic [7:0]           lane_b;
    logic [15:0]          lane_h;
    logic [31:0]          load_ext;

    assign is_store = IN_READ_WRITE[3];
    assign funct3   = IN_READ_WRITE[2:0];
    assign timeout  = (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGNED_TRAP_EN
    always_comb begin
        case (funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~IN_ADDRESS[0];
            3'b010:         aligned = (IN_ADDRESS[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end
`else
    assign aligned = 1'b1;
`endif

    assign mem.MEM_ADDRESS = {IN_ADDRESS[31:2], 2'b00};

    always_comb begin
        mem.MEM_WRITEDATA = IN_DATA2;
        mem.MEM_BYTEEN    = 4'b1111;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    mem.MEM_WRITEDATA = {4{IN_DATA2[7:0]}};
                    mem.MEM_BYTEEN    = 4'b0001 << IN_ADDRESS[1:0];
                end
                2'b01: begin
                    mem.MEM_WRITEDATA = {2{IN_DATA2[15:0]}};
                    mem.MEM_BYTEEN    = 4'b0011 << {IN_ADDRESS[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (IN_ADDRESS[1:0])
            2'b00:   lane_b = mem.MEM_READDATA[7:0];
            2'b01:   lane_b = mem.MEM_READDATA[15:8];
            2'b10:   lane_b = mem.MEM_READDATA[23:16];
            default: lane_b = mem.MEM_READDATA[31:24];
        endcase
        lane_h = IN_ADDRESS[1] ? mem.MEM_READDATA[31:16] : mem.MEM_READDATA[15:0];
        case (funct3)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = mem.MEM_READDATA;
        endcase
    end

    // BUSYWAIT in IDLE is combinational, so reset must mask it directly to drop the stall at once.
    always_comb begin
        state_n       = state;
        BUSYWAIT      = 1'b0;
        mem.MEM_READ  = 1'b0;
        mem.MEM_WRITE = 1'b0;
        case (state)
            S_IDLE: begin
                BUSYWAIT = IN_DATAMEMSEL & aligned & RESET;
                if (IN_DATAMEMSEL)
                    state_n = aligned ? S_ACCESS : S_DONE;
            end
            S_ACCESS: begin
                BUSYWAIT      = 1'b1;
                mem.MEM_READ  = ~is_store;
                mem.MEM_WRITE = is_store;
                if (!mem.MEM_BUSYWAIT || timeout)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            LOAD_DATA  <= 32'd0;
            MISALIGNED <= 1'b0;
            BUS_ERROR  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state == S_ACCESS) ? cnt + 1'b1 : '0;
`ifdef MISALIGNED_TRAP_EN
            MISALIGNED <= (state == S_IDLE) && IN_DATAMEMSEL && !aligned;
`else
            MISALIGNED <= 1'b0;
`endif
            // completion takes priority over a timeout on the same edge
            BUS_ERROR <= (state == S_ACCESS) && mem.MEM_BUSYWAIT && timeout;
            if ((state == S_ACCESS) && !mem.MEM_BUSYWAIT && !is_store)
                LOAD_DATA <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout (8 cycles) and a bench-driven memory.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] IN_ADDRESS = '0;
    logic [31:0] IN_DATA2 = '0;
    logic        IN_DATAMEMSEL = 1'b0;
    logic [3:0]  IN_READ_WRITE = '0;
    logic [31:0] LOAD_DATA;
    logic        BUSYWAIT, MISALIGNED, BUS_ERROR;

    mem_access_unit_if mif ();

    mem_access_unit #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_ADDRESS(IN_ADDRESS), .IN_DATA2(IN_DATA2),
        .IN_DATAMEMSEL(IN_DATAMEMSEL), .IN_READ_WRITE(IN_READ_WRITE),
        .mem(mif.master),
        .LOAD_DATA(LOAD_DATA), .BUSYWAIT(BUSYWAIT),
        .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // observations of the last access
    int          busy_n, rd_n, wr_n, mis_n, berr_n;
    logic [31:0] a_seen, wd_seen, ld_seen;
    logic [3:0]  be_seen;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

    task automatic access(input string tag, input logic [3:0] rw, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] rd, input int waits);
        int  strobes = 0;
        bit  done = 0;
        busy_n = 0; rd_n = 0; wr_n = 0; mis_n = 0; berr_n = 0;
        a_seen = 'x; wd_seen = 'x; be_seen = 'x;
        @(negedge CLK);
        IN_READ_WRITE = rw; IN_ADDRESS = addr; IN_DATA2 = d; IN_DATAMEMSEL = 1'b1;
        mif.MEM_READDATA = rd;
        for (int c = 0; c < 100 && !done; c++) begin
            mif.MEM_BUSYWAIT = (strobes < waits);
            #1;
            if (BUSYWAIT) busy_n++;
            if (mif.MEM_READ) rd_n++;
            if (mif.MEM_WRITE) wr_n++;
            if (mif.MEM_READ || mif.MEM_WRITE) begin
                strobes++;
                a_seen = mif.MEM_ADDRESS; wd_seen = mif.MEM_WRITEDATA; be_seen = mif.MEM_BYTEEN;
            end
            if (MISALIGNED) mis_n++;
            if (BUS_ERROR) berr_n++;
            done = !BUSYWAIT;
            @(negedge CLK);
        end
        chk({tag, ".terminated"}, 32'(done), 32'd1);
        IN_DATAMEMSEL = 1'b0;
        mif.MEM_BUSYWAIT = 1'b0;
        #1;
        if (MISALIGNED) mis_n++;
        if (BUS_ERROR) berr_n++;
        ld_seen = LOAD_DATA;
        chk({tag, ".stall_released"}, 32'(BUSYWAIT), 32'd0);
    endtask

    task automatic expect_cnt(input string tag, input int busy, input int rds, input int wrs,
                              input int mis, input int berr);
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(busy));
        chk({tag, ".read_cycles"}, 32'(rd_n), 32'(rds));
        chk({tag, ".write_cycles"}, 32'(wr_n), 32'(wrs));
        chk({tag, ".misaligned"}, 32'(mis_n), 32'(mis));
        chk({tag, ".bus_error"}, 32'(berr_n), 32'(berr));
    endtask

    initial begin
        mif.MEM_READDATA = '0;
        mif.MEM_BUSYWAIT = 1'b0;
        #12;
        chk("rst.read", 32'(mif.MEM_READ), 0);
        chk("rst.write", 32'(mif.MEM_WRITE), 0);
        chk("rst.busywait", 32'(BUSYWAIT), 0);
        chk("rst.load_data", LOAD_DATA, 0);
        chk("rst.flags", {30'd0, MISALIGNED, BUS_ERROR}, 0);
        RESET = 1'b1;
        @(negedge CLK); #1;
        chk("idle.no_req_busywait", 32'(BUSYWAIT), 0);

        access("lw", LW, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        expect_cnt("lw", 2, 1, 0, 0, 0);
        chk("lw.addr", a_seen, 32'h100);
        chk("lw.byteen", 32'(be_seen), 32'hF);
        chk("lw.load", ld_seen, 32'hDEADBEEF);

        access("lb", LB, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        chk("lb.load", ld_seen, 32'hFFFFFF80);
        access("lbu", LBU, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        chk("lbu.load", ld_seen, 32'h00000080);
        access("lh", LH, 32'h102, 32'h0, 32'h80011234, 2);
        expect_cnt("lh", 4, 3, 0, 0, 0);
        chk("lh.load", ld_seen, 32'hFFFF8001);
        access("lhu", LHU, 32'h100, 32'h0, 32'h1234F00D, 0);
        chk("lhu.load", ld_seen, 32'h0000F00D);

        access("sh", SH, 32'h202, 32'h1234ABCD, 32'h0, 4);
        expect_cnt("sh", 6, 0, 5, 0, 0);
        chk("sh.addr", a_seen, 32'h200);
        chk("sh.wdata", wd_seen, 32'hABCDABCD);
        chk("sh.byteen", 32'(be_seen), 32'hC);
        chk("sh.load_kept", ld_seen, 32'h0000F00D);

        access("sb", SB, 32'h101, 32'h000000EF, 32'h0, 0);
        chk("sb.wdata", wd_seen, 32'hEFEFEFEF);
        chk("sb.byteen", 32'(be_seen), 32'h2);
        access("sw", SW, 32'h300, 32'h89ABCDEF, 32'h0, 1);
        expect_cnt("sw", 3, 0, 2, 0, 0);
        chk("sw.wdata", wd_seen, 32'h89ABCDEF);
        chk("sw.byteen", 32'(be_seen), 32'hF);

        access("lw_mis", LW, 32'h101, 32'h0, 32'h5A5AA5A5, 0);
`ifdef MISALIGNED_TRAP_EN
        expect_cnt("lw_mis", 0, 0, 0, 1, 0);
        chk("lw_mis.load_kept", ld_seen, 32'h0000F00D);
`else
        expect_cnt("lw_mis", 2, 1, 0, 0, 0);
        chk("lw_mis.addr", a_seen, 32'h100);
        chk("lw_mis.load", ld_seen, 32'h5A5AA5A5);
`endif

        access("lw_limit", LW, 32'h400, 32'h0, 32'hCAFEF00D, 7);
        expect_cnt("lw_limit", 9, 8, 0, 0, 0);
        chk("lw_limit.load", ld_seen, 32'hCAFEF00D);

        access("lw_tmo", LW, 32'h404, 32'h0, 32'h11111111, 1000);
        expect_cnt("lw_tmo", 9, 8, 0, 0, 1);
        chk("lw_tmo.load_kept", ld_seen, 32'hCAFEF00D);
        @(negedge CLK); #1;
        chk("lw_tmo.idle_read", 32'(mif.MEM_READ), 0);

        // reset during the second ACCESS cycle, request held throughout
        @(negedge CLK);
        IN_READ_WRITE = LW; IN_ADDRESS = 32'h500; IN_DATAMEMSEL = 1'b1;
        mif.MEM_READDATA = 32'h0BADCAFE; mif.MEM_BUSYWAIT = 1'b1;
        #1 chk("rstmid.idle_busy", 32'(BUSYWAIT), 1);
        @(negedge CLK); #1 chk("rstmid.acc1_read", 32'(mif.MEM_READ), 1);
        @(negedge CLK); #1 chk("rstmid.acc2_read", 32'(mif.MEM_READ), 1);
        RESET = 1'b0;
        #1;
        chk("rstmid.read_drop", 32'(mif.MEM_READ), 0);
        chk("rstmid.busy_drop", 32'(BUSYWAIT), 0);
        chk("rstmid.load_clr", LOAD_DATA, 0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rstmid.reissue_busy", 32'(BUSYWAIT), 1);
        chk("rstmid.reissue_idle", 32'(mif.MEM_READ), 0);
        @(negedge CLK); #1;
        chk("rstmid.reissue_read", 32'(mif.MEM_READ), 1);
        mif.MEM_BUSYWAIT = 1'b0;
        @(negedge CLK); #1;
        chk("rstmid.done_busy", 32'(BUSYWAIT), 0);
        chk("rstmid.done_load", LOAD_DATA, 32'h0BADCAFE);
        IN_DATAMEMSEL = 1'b0;
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
